// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter stage of the single-cycle RV32I core.
// Selects the next PC from the branch and jump controls, and holds the architectural PC.
// Drives the instruction fetch with a req/ack handshake.
// A misaligned control-flow target redirects execution to TRAP_VEC.
// Optional macro PC_PERF_CNT_EN adds saturating redirect, instret and trap counters.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        BrTaken,
    input  logic        Jal,
    input  logic        Jalr,
    input  logic [31:0] imm,
    input  logic [31:0] rs1,
    input  logic        stall,
    input  logic        imem_ack,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        trap,
    output logic [31:0] trap_epc
`ifdef PC_PERF_CNT_EN
    ,
    output logic [31:0] redirect_cnt,
    output logic [31:0] instret_cnt,
    output logic [15:0] trap_cnt
`endif
);

    typedef enum logic {
        FETCH = 1'b0,
        TRAP  = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] epc_q, epc_d;
    logic        trap_q, trap_d;
    logic        req_q, req_d;

    logic [31:0] br_tgt, jal_tgt, jalr_sum, jalr_tgt, tgt, next_pc;
    logic        redirect, misaligned, commit;

    // Target selection: Jalr > Jal > BrTaken > sequential
    always_comb begin
        br_tgt   = pc_q + imm;
        jal_tgt  = pc_q + imm;
        jalr_sum = rs1 + imm;
        jalr_tgt = {jalr_sum[31:1], 1'b0};
        redirect = Jalr | Jal | BrTaken;
        if (Jalr) begin
            tgt = jalr_tgt;
        end else if (Jal) begin
            tgt = jal_tgt;
        end else begin
            tgt = br_tgt;
        end
        next_pc    = redirect ? tgt : pc_plus4;
        misaligned = redirect & tgt[1];
        commit     = (state_q == FETCH) & imem_ack & ~stall;
    end

    // Next-state logic for the FETCH/TRAP sequencer and its registered outputs
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        epc_d   = epc_q;
        trap_d  = 1'b0;
        req_d   = 1'b1;
        case (state_q)
            FETCH: begin
                if (commit) begin
                    if (misaligned) begin
                        epc_d   = pc_q;
                        state_d = TRAP;
                        trap_d  = 1'b1;
                        req_d   = 1'b0;
                    end else begin
                        pc_d = next_pc;
                    end
                end
            end
            TRAP: begin
                pc_d    = TRAP_VEC;
                state_d = FETCH;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // Architectural state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            epc_q   <= '0;
            trap_q  <= 1'b0;
            req_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            trap_q  <= trap_d;
            req_q   <= req_d;
        end
    end

    // req_q already tracks FETCH; masking with rst keeps the request low while reset is held
    assign imem_req  = req_q & ~rst;
    assign pc        = pc_q;
    assign imem_addr = pc_q;
    assign pc_plus4  = pc_q + 32'd4;
    assign trap      = trap_q;
    assign trap_epc  = epc_q;

`ifdef PC_PERF_CNT_EN
    logic [31:0] redirect_cnt_q, redirect_cnt_d;
    logic [31:0] instret_cnt_q, instret_cnt_d;
    logic [15:0] trap_cnt_q, trap_cnt_d;

    // Saturating performance counters, advanced only on committed instructions
    always_comb begin
        redirect_cnt_d = redirect_cnt_q;
        instret_cnt_d  = instret_cnt_q;
        trap_cnt_d     = trap_cnt_q;
        if (commit) begin
            if (misaligned) begin
                if (trap_cnt_q != '1) trap_cnt_d = trap_cnt_q + 16'd1;
            end else begin
                if (instret_cnt_q != '1) instret_cnt_d = instret_cnt_q + 32'd1;
                if (redirect && (next_pc != pc_plus4) && (redirect_cnt_q != '1)) begin
                    redirect_cnt_d = redirect_cnt_q + 32'd1;
                end
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_cnt_q <= '0;
            instret_cnt_q  <= '0;
            trap_cnt_q     <= '0;
        end else begin
            redirect_cnt_q <= redirect_cnt_d;
            instret_cnt_q  <= instret_cnt_d;
            trap_cnt_q     <= trap_cnt_d;
        end
    end

    assign redirect_cnt = redirect_cnt_q;
    assign instret_cnt  = instret_cnt_q;
    assign trap_cnt     = trap_cnt_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer.
// Covers reset, sequential fetch, stalls, jump priority, misaligned traps, PC wrap and reset during a trap.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        BrTaken, Jal, Jalr, stall, imem_ack;
    logic [31:0] imm, rs1;
    logic        imem_req, trap;
    logic [31:0] imem_addr, pc, pc_plus4, trap_epc;
`ifdef PC_PERF_CNT_EN
    logic [31:0] redirect_cnt, instret_cnt;
    logic [15:0] trap_cnt;
`endif

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    pc_sequencer #(
        .RESET_PC(32'h0000_0000),
        .TRAP_VEC(32'h0000_0100)
    ) dut (
        .clk(clk),
        .rst(rst),
        .BrTaken(BrTaken),
        .Jal(Jal),
        .Jalr(Jalr),
        .imm(imm),
        .rs1(rs1),
        .stall(stall),
        .imem_ack(imem_ack),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .pc(pc),
        .pc_plus4(pc_plus4),
        .trap(trap),
        .trap_epc(trap_epc)
`ifdef PC_PERF_CNT_EN
        ,
        .redirect_cnt(redirect_cnt),
        .instret_cnt(instret_cnt),
        .trap_cnt(trap_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle before sampling or driving
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctrl();
        BrTaken = 1'b0;
        Jal     = 1'b0;
        Jalr    = 1'b0;
        imm     = '0;
        rs1     = '0;
        stall   = 1'b0;
        imem_ack = 1'b1;
    endtask

    task automatic jump_to(input logic [31:0] addr);
        clear_ctrl();
        Jalr = 1'b1;
        rs1  = addr;
        tick();
        clear_ctrl();
        check("jump_to", pc, addr);
    endtask

    initial begin
        clear_ctrl();
        rst = 1'b1;

        // Reset held for two cycles
        tick();
        check("rst_req0", {31'b0, imem_req}, 32'h0);
        check("rst_pc", pc, 32'h0);
        check("rst_trap", {31'b0, trap}, 32'h0);
        check("rst_epc", trap_epc, 32'h0);
        tick();
        check("rst_req1", {31'b0, imem_req}, 32'h0);
        rst = 1'b0;
        #1;
        check("post_rst_req", {31'b0, imem_req}, 32'h1);
        check("seq_pc0", pc, 32'h0);
        check("seq_addr0", imem_addr, 32'h0);
        check("seq_p4_0", pc_plus4, 32'h4);
        tick(); check("seq_pc4", pc, 32'h4);
        tick(); check("seq_pc8", pc, 32'h8);
        tick(); check("seq_pcC", pc, 32'hC);

        // No ack: PC holds
        imem_ack = 1'b0;
        tick(); check("noack_hold", pc, 32'hC);
        imem_ack = 1'b1;

        // Taken branch under stall
        jump_to(32'h10);
        BrTaken = 1'b1;
        imm     = 32'hFFFF_FFF8;
        stall   = 1'b1;
        tick(); check("stall_hold1", pc, 32'h10);
        tick(); check("stall_hold2", pc, 32'h10);
        stall = 1'b0;
        tick(); check("br_back", pc, 32'h08);

        // Jump priority: Jalr wins, bit0 cleared
        jump_to(32'h40);
        check("p4_at_40", pc_plus4, 32'h44);
        Jal = 1'b1; Jalr = 1'b1; BrTaken = 1'b1;
        rs1 = 32'h1001; imm = 32'h10;
        tick(); check("jalr_prio", pc, 32'h1010);

        // Jal beats BrTaken: both compute pc+imm, so check the aligned landing
        clear_ctrl();
        Jal = 1'b1; BrTaken = 1'b1; imm = 32'h20;
        tick(); check("jal_tgt", pc, 32'h1030);

        // Misaligned branch target traps
        jump_to(32'h20);
        BrTaken = 1'b1;
        imm     = 32'h6;
        tick();
        check("trap_pulse", {31'b0, trap}, 32'h1);
        check("trap_req0", {31'b0, imem_req}, 32'h0);
        check("trap_epc", trap_epc, 32'h20);
        check("trap_pc_hold", pc, 32'h20);
        clear_ctrl();
        stall = 1'b1; imem_ack = 1'b0;
        tick();
        check("trap_vec", pc, 32'h100);
        check("trap_clear", {31'b0, trap}, 32'h0);
        check("trap_req1", {31'b0, imem_req}, 32'h1);
        check("epc_held", trap_epc, 32'h20);

        // Misaligned Jalr target (bit0 cleared, bit1 set) also traps
        jump_to(32'h200);
        Jalr = 1'b1; rs1 = 32'h303; imm = 32'h0;
        tick();
        check("jalr_mis_trap", {31'b0, trap}, 32'h1);
        check("jalr_mis_epc", trap_epc, 32'h200);
        clear_ctrl();
        tick();
        check("jalr_mis_vec", pc, 32'h100);

        // PC wrap-around
        jump_to(32'hFFFF_FFFC);
        check("wrap_p4", pc_plus4, 32'h0);
        tick(); check("wrap_pc", pc, 32'h0);

        // Reset while in TRAP
        jump_to(32'h20);
        BrTaken = 1'b1; imm = 32'h6;
        tick();
        check("mid_trap", {31'b0, trap}, 32'h1);
        clear_ctrl();
        rst = 1'b1;
        tick();
        check("mtr_pc", pc, 32'h0);
        check("mtr_trap", {31'b0, trap}, 32'h0);
        check("mtr_epc", trap_epc, 32'h0);
        rst = 1'b0;
        tick();
        check("mtr_no_vec", pc, 32'h4);

`ifdef PC_PERF_CNT_EN
        // Perf counters: 5 sequential, 2 taken branches, 1 trap
        clear_ctrl();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("cnt_rst_ir", instret_cnt, 32'h0);
        for (int i = 0; i < 5; i++) tick();
        check("cnt_seq_pc", pc, 32'h14);
        BrTaken = 1'b1; imm = 32'h8;
        tick(); tick();
        check("cnt_br_pc", pc, 32'h24);
        imm = 32'h6;
        tick();
        clear_ctrl();
        tick();
        check("cnt_instret", instret_cnt, 32'd7);
        check("cnt_redirect", redirect_cnt, 32'd2);
        check("cnt_trap", {16'b0, trap_cnt}, 32'd1);
        stall = 1'b1;
        tick();
        check("cnt_stall", instret_cnt, 32'd7);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Global time bound so the bench never hangs
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter stage directly downstream of the branch comparator in the single-cycle RV32I core.
- Consumes BrTaken plus jump controls, selects the next PC, and holds the architectural PC register.
- Drives the instruction-memory fetch with a req/ack handshake.
- Detects misaligned control-flow targets and redirects to a trap vector.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TRAP_VEC, 32'h0000_0100, PC loaded on a misaligned-target trap; must be 4-byte aligned.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- BrTaken  in  1  branch-taken result from the comparator (already qualified by Branch)
- Jal  in  1  current instruction is JAL
- Jalr  in  1  current instruction is JALR
- imm  in  32  sign-extended B/J/I immediate of the current instruction
- rs1  in  32  rs1 operand, used for JALR
- stall  in  1  external hold; PC does not advance
- imem_ack  in  1  instruction memory returned a valid instruction for imem_addr this cycle
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address (equals pc)
- pc  out  32  current PC
- pc_plus4  out  32  pc + 4, used as the link value for JAL/JALR
- trap  out  1  one-cycle pulse on misaligned-target trap
- trap_epc  out  32  PC of the faulting instruction; held until the next trap

Behaviour:
- Reset (rst=1 at clk edge, any state):
  - pc=RESET_PC, trap=0, trap_epc=0, state=FETCH.
  - imem_req is 0 during the reset cycle and 1 from the first cycle after reset.
  - Reset overrides everything, including an in-flight ack or trap.
- Target computation, combinational, 32-bit wrap-around with no overflow detection:
  - br_tgt = pc + imm
  - jal_tgt = pc + imm
  - jalr_tgt = (rs1 + imm) with bit0 cleared
- next_pc priority: Jalr > Jal > BrTaken > pc_plus4.
  - If more than one of Jal/Jalr is high, Jalr wins.
  - BrTaken is ignored when Jal or Jalr is high.
- Misaligned: selected target has bit1 = 1 and a redirect was taken (Jalr, Jal or BrTaken).
  - pc_plus4 is never misaligned.
- FSM states: FETCH, TRAP.
  - FETCH:
    - imem_req=1.
    - Commit edge = imem_ack=1 and stall=0.
    - On commit with no misalignment: pc <= next_pc; stay in FETCH.
    - On commit with misalignment: trap_epc <= pc; go to TRAP; pc unchanged.
    - No commit (ack=0 or stall=1): pc holds, all inputs ignored. Latency is therefore 1 cycle per instruction when ack is continuously high.
  - TRAP (exactly one cycle):
    - trap=1, imem_req=0.
    - At the edge: pc <= TRAP_VEC; go to FETCH.
    - stall and imem_ack are ignored in TRAP.
- imem_addr = pc at all times; imem_req is driven from state only, with no combinational path from ack.
- pc_plus4 = pc + 4, wrapping 32'hFFFF_FFFC -> 32'h0000_0000.
- All registered outputs update only on clk rising edge.

Optional Feature:
- Macro: PC_PERF_CNT_EN.
- When defined, adds three outputs:
  - redirect_cnt (32): counts commits where next_pc != pc_plus4 via Jal, Jalr or BrTaken, misaligned traps excluded.
  - instret_cnt (32): counts all non-trap commits.
  - trap_cnt (16).
- Counter rules:
  - All counters saturate at all-ones.
  - All reset to 0 on rst.
  - No increment during a stall or a non-acked cycle.
- When undefined: ports and logic are absent; the rest of the behaviour is identical.

Test Plan:
- Reset then sequential fetch: rst for 2 cycles, ack=1, no control -> pc 0x0, 0x4, 0x8, 0xC on successive cycles; imem_req=0 during reset, 1 after.
- Taken branch with stall: pc=0x10, BrTaken=1, imm=-8, stall=1 for 2 cycles then 0 -> pc holds 0x10 two cycles, then 0x08.
- Jump priority: pc=0x40, Jal=1, Jalr=1, BrTaken=1, rs1=0x1001, imm=0x10 -> pc=0x1010 (bit0 cleared); pc_plus4 was 0x44 while at 0x40.
- Misaligned trap: pc=0x20, BrTaken=1, imm=0x6 -> next cycle state TRAP with trap=1, imem_req=0, trap_epc=0x20; following cycle pc=0x100.
- Wrap and mid-trap reset:
  - pc=0xFFFF_FFFC, ack=1 -> pc=0x0.
  - rst asserted during TRAP -> pc=RESET_PC, trap=0, no jump to TRAP_VEC.
- PC_PERF_CNT_EN:
  - 5 sequential commits + 2 taken branches + 1 trap -> instret_cnt=7, redirect_cnt=2, trap_cnt=1.
  - Preloaded to saturation, one further commit -> counters stay at all-ones.
